// File: rtl/wb_retire_unit.sv
// Write-back/retire stage: picks ALU, load or PC+4 data, checks it, and drives a registered one-cycle write strobe.
// Latency 1 after accept or after load data; in_ready drops only while a load waits for dmem_rvalid.
module wb_retire_unit #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [XLEN-1:0]             alu_result_in,
   input  logic [XLEN-1:0]             pc_plus_4_in,
   input  logic [REG_ADDR_W-1:0]       rd_addr_in,
   input  logic                        reg_write_en_in,
   input  logic [1:0]                  mem_to_reg_in,
   input  logic [2:0]                  load_funct3_in,
   input  logic [$clog2(XLEN/8)-1:0]   load_offset_in,
   input  logic                        dmem_rvalid,
   input  logic [XLEN-1:0]             dmem_rdata,
   input  logic                        flush,
   output logic [XLEN-1:0]             wb_write_data_out,
   output logic [REG_ADDR_W-1:0]       wb_write_addr_out,
   output logic                        wb_write_en_out,
   output logic                        err_out,
   output logic [CNT_W-1:0]            retire_count_out
);
   localparam int OFF_W = $clog2(XLEN/8);

   typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

   state_t                  r_state, w_state_nxt;
   logic [REG_ADDR_W-1:0]   r_rd;
   logic                    r_we;
   logic [2:0]              r_f3;
   logic [OFF_W-1:0]        r_off;
   logic [XLEN-1:0]         r_data;
   logic [REG_ADDR_W-1:0]   r_addr;
   logic                    r_en;
   logic                    r_err;
   logic [CNT_W-1:0]        r_count;

   logic                    w_accept, w_is_load, w_complete, w_latch, w_in_wait;
   logic [1:0]              w_sel;
   logic [2:0]              w_f3;
   logic [OFF_W-1:0]        w_off;
   logic [REG_ADDR_W-1:0]   w_rd;
   logic                    w_we;
   logic [XLEN-1:0]         w_shifted, w_ld, w_val;
   logic                    w_f3_ok, w_misal, w_err, w_en;

   assign in_ready  = (r_state == IDLE) && rst_n;
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_is_load = (mem_to_reg_in == 2'b01);

   always_comb begin
      w_state_nxt = r_state;
      w_complete  = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_load && !dmem_rvalid) begin
                  w_latch     = 1'b1;
                  w_state_nxt = WAIT_LOAD;
               end else begin
                  w_complete  = 1'b1;
               end
            end
         end
         WAIT_LOAD: begin
            // flush beats a load response arriving in the same cycle
            if (flush) begin
               w_state_nxt = IDLE;
            end else if (dmem_rvalid) begin
               w_complete  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A waiting load completes from its latched fields, everything else straight from the inputs.
   assign w_in_wait = (r_state == WAIT_LOAD);
   assign w_sel     = w_in_wait ? 2'b01 : mem_to_reg_in;
   assign w_f3      = w_in_wait ? r_f3  : load_funct3_in;
   assign w_off     = w_in_wait ? r_off : load_offset_in;
   assign w_rd      = w_in_wait ? r_rd  : rd_addr_in;
   assign w_we      = w_in_wait ? r_we  : reg_write_en_in;
   assign w_shifted = dmem_rdata >> {w_off, 3'b000};

   always_comb begin
      w_ld    = '0;
      w_f3_ok = 1'b1;
      w_misal = 1'b0;
      case (w_f3)
         3'b000: w_ld = XLEN'($signed(w_shifted[7:0]));
         3'b001: begin w_ld = XLEN'($signed(w_shifted[15:0])); w_misal = w_off[0];       end
         3'b010: begin w_ld = XLEN'($signed(w_shifted[31:0])); w_misal = |w_off[1:0];    end
         3'b100: w_ld = XLEN'(w_shifted[7:0]);
         3'b101: begin w_ld = XLEN'(w_shifted[15:0]);          w_misal = w_off[0];       end
         3'b011: begin w_ld = w_shifted; w_misal = |w_off; w_f3_ok = (XLEN == 64);       end
         3'b110: begin w_ld = XLEN'(w_shifted[31:0]); w_misal = |w_off[1:0]; w_f3_ok = (XLEN == 64); end
         default: w_f3_ok = 1'b0;
      endcase
   end

   always_comb begin
      w_val = '0;
      case (w_sel)
         2'b00:   w_val = alu_result_in;
         2'b01:   w_val = w_ld;
         2'b10:   w_val = pc_plus_4_in;
         default: w_val = '0;
      endcase
   end

   assign w_err = (w_sel == 2'b11) || ((w_sel == 2'b01) && (!w_f3_ok || w_misal));
   assign w_en  = w_we && (w_rd != '0) && !w_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rd    <= '0;
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_off   <= '0;
         r_data  <= '0;
         r_addr  <= '0;
         r_en    <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_en    <= w_complete && w_en;
         r_err   <= w_complete && w_err;
         r_data  <= (w_complete && w_en) ? w_val : '0;
         if (w_complete) begin
            r_addr  <= w_rd;
            r_count <= r_count + CNT_W'(1);
         end
         if (w_latch) begin
            r_rd  <= rd_addr_in;
            r_we  <= reg_write_en_in;
            r_f3  <= load_funct3_in;
            r_off <= load_offset_in;
         end
      end
   end

   assign wb_write_data_out = r_data;
   assign wb_write_addr_out = r_addr;
   assign wb_write_en_out   = r_en;
   assign err_out           = r_err;
   assign retire_count_out  = r_count;
endmodule

// File: doc/wb_retire_unit.md
WB_RETIRE_UNIT -- requirements
Module: wb_retire_unit

Interface
REQ-001 Parameter XLEN, default 32, register/data width; legal values 32 or 64.
REQ-002 Parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 Parameter CNT_W, default 64, retire counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  MEM/WB entry present.
REQ-007 in_ready  out  1  unit can accept an entry this cycle.
REQ-008 alu_result_in  in  XLEN  ALU result.
REQ-009 pc_plus_4_in  in  XLEN  return address for JAL/JALR.
REQ-010 rd_addr_in  in  REG_ADDR_W  destination register.
REQ-011 reg_write_en_in  in  1  entry writes the register file.
REQ-012 mem_to_reg_in  in  2  source select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-013 load_funct3_in  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD, 110 LWU legal only when XLEN=64.
REQ-014 load_offset_in  in  log2(XLEN/8)  byte offset of load address within the data word.
REQ-015 dmem_rvalid  in  1  raw load data valid this cycle.
REQ-016 dmem_rdata  in  XLEN  raw, unaligned-extracted memory word.
REQ-017 flush  in  1  discard accepted/pending entry.
REQ-018 wb_write_data_out  out  XLEN  registered write-back data.
REQ-019 wb_write_addr_out  out  REG_ADDR_W  registered write address.
REQ-020 wb_write_en_out  out  1  registered one-cycle write strobe.
REQ-021 err_out  out  1  one-cycle pulse: reserved select, illegal funct3 or misaligned load.
REQ-022 retire_count_out  out  CNT_W  count of retired entries.

Function
REQ-023 FSM states: IDLE, WAIT_LOAD; in_ready SHALL be 1 only in IDLE with rst_n high.
REQ-024 Accept = in_valid & in_ready & ~flush; flush in IDLE SHALL drop the offered entry with no write, no count.
REQ-025 Accepted non-load entry: outputs SHALL update on the next edge (latency 1), data per mem_to_reg_in 00/10.
REQ-026 Accepted load with dmem_rvalid same cycle: complete with latency 1, stay IDLE.
REQ-027 Accepted load without dmem_rvalid: latch rd, write enable, funct3, offset; go WAIT_LOAD.
REQ-028 WAIT_LOAD: on dmem_rvalid, complete (outputs next edge), return IDLE; otherwise hold, no timeout.
REQ-029 flush in WAIT_LOAD SHALL abandon the load, no write, no count, return IDLE; flush wins over simultaneous dmem_rvalid.
REQ-030 Load extraction: select byte/half/word at offset, sign-extend (LB/LH/LW/LD) or zero-extend (LBU/LHU/LWU) to XLEN.
REQ-031 Misaligned (half at odd offset, word offset not multiple of 4, LD offset non-zero): err_out pulse, write suppressed, entry counts as retired.
REQ-032 wb_write_en_out SHALL be 1 only if reg_write_en=1, rd≠0, select legal, no error; data SHALL be 0 when strobe is 0.
REQ-033 mem_to_reg=11 or illegal funct3: err_out pulse, write suppressed, entry counts as retired.
REQ-034 dmem_rvalid in IDLE without an accepted load SHALL be ignored.
REQ-035 retire_count_out SHALL increment by 1 per completed (non-flushed) entry, wrapping modulo 2^CNT_W.
REQ-036 Throughput: one non-load or same-cycle load entry per cycle, back-to-back.

Reset
REQ-037 rst_n low at an edge: state IDLE, all outputs 0, retire_count_out 0, latched load fields cleared.
REQ-038 Reset during WAIT_LOAD SHALL discard the pending load; a dmem_rvalid in the first cycle after reset is ignored.

Verification
REQ-039 ALU entry alu=0x0000_1234, rd=5, we=1, sel=00 -> next cycle data 0x0000_1234, addr 5, en 1, count 1.
REQ-040 LB offset 2, dmem_rdata 0x0080_0000 one cycle late -> WAIT_LOAD then data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-041 LH offset 1 -> err_out 1, en 0, count increments; sel=11 -> err_out 1, en 0.
REQ-042 JAL pc+4=0x0000_0104 rd=0 -> en 0, data 0, count increments.
REQ-043 Load pending, flush and dmem_rvalid same cycle -> no write, count unchanged, in_ready 1 next cycle.
REQ-044 CNT_W=4, 17 back-to-back ALU entries -> count 1 after wrap, en high 17 consecutive cycles.
